sc_dbus: RTL and testbench
==========================

Name: sc_dbus

Overview:
Data-side bus stage directly downstream of the single-cycle CPU. It consumes the CPU's data address (ALU result), store data and memory write strobe, and returns load data in the same cycle. The address space is decoded onto a local data RAM, a 32-bit timer with compare, and a UART transmitter with a TX FIFO. This lets programs run on the single-cycle core and produce observable serial output.

Parameters:
RAM_WORDS, 1024, data RAM depth in 32-bit words; power of two, max 1024.
FIFO_DEPTH, 8, UART TX FIFO entries of 8 bits; power of two.
CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 2.

Ports:
clk  in  1  system clock; all state updates on rising edge.
clr  in  1  synchronous active-high reset.
addr  in  32  byte address from CPU ALU result; addr[1:0] ignored.
wdata  in  32  store data (CPU rt register value).
wmem  in  1  store strobe; write occurs at the rising edge.
rdata  out  32  load data; combinational from addr and current state.
txd  out  1  UART serial output; idles high.
timer_irq  out  1  equals TIMER_STAT[0].

Behaviour:
- Reset (clr=1 at an edge): count=0, cmp=0xFFFF_FFFF, match flag=0, FIFO empty (rd/wr pointers 0), overflow=0, UART FSM=IDLE, txd=1. RAM contents are not cleared.
- Decode with word address (addr[1:0] don't-care):
  - RAM: addr[31:12]==0, index addr[11:2] mod RAM_WORDS. Read is combinational; write is at the edge.
  - 0x8000_0000 TIMER_COUNT, R/W.
  - 0x8000_0004 TIMER_CMP, R/W.
  - 0x8000_0008 TIMER_STAT, R: {31'b0, flag}. W: wdata[0]=1 clears flag.
  - 0x8000_0010 UART_TXDATA, W: push wdata[7:0]. R: returns 0.
  - 0x8000_0014 UART_STAT, R: {24'b0, count[3:0], overflow, busy, full, empty}. W: wdata[3]=1 clears overflow.
  - Unmapped addresses: reads return 0; writes have no effect.
- Timer:
  - count increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - A write to COUNT loads wdata and overrides the increment that cycle.
  - At each edge, if the pre-edge count == cmp, flag is set to 1.
  - If a set and a clear of flag occur in the same cycle, set wins.
- TX FIFO:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - count ranges 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1, busy=0. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. Go to STOP after 8 bits, LSB first.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the final STOP cycle, if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
  - busy=1 in every state except IDLE. A frame is exactly 10*CLKS_PER_BIT cycles.
- A push into an empty FIFO while IDLE: the pop occurs on the next edge, and txd falls one cycle after the store edge.
- Reset mid-frame: txd returns to 1 and the FIFO is discarded; no partial frame continues.

Test Plan:
- Reset, then read 0x8000_0014 -> rdata=0x0000_0001. txd=1. Read 0x8000_0004 -> 0xFFFF_FFFF.
- Store 0xDEAD_BEEF to 0x0000_0040, then read 0x0000_0040 and 0x0000_0043 -> both return 0xDEAD_BEEF. Read 0x0000_1000 -> 0.
- Write COUNT=0xFFFF_FFFE and CMP=0x0000_0001 -> count wraps to 0 after 2 cycles. flag and timer_irq rise on the edge after count==1. Write STAT=1 -> flag=0.
- Push 0x55 with CLKS_PER_BIT=4 -> txd produces 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each bit 4 cycles, 40 cycles total. Push 0xA3 during STOP -> next start bit follows with no idle cycles.
- Push 10 bytes in 10 consecutive cycles while IDLE -> 9 accepted (one popped in flight), overflow=1, full=1. Write STAT with bit3=1 -> overflow=0.
- Assert clr during the DATA state -> next cycle txd=1, UART_STAT=0x01, and no further frames are sent.

Source files
------------

// File: rtl/sc_dbus.sv
// Data-side bus stage for the single-cycle CPU: decodes loads/stores onto a
// local data RAM, a free-running timer with compare, and a FIFO-fed UART TX.
module sc_dbus #(
    parameter int unsigned RAM_WORDS    = 1024,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wmem,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        timer_irq
);

    localparam int unsigned RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CPB_W   = $clog2(CLKS_PER_BIT);

    localparam logic [29:0] A_COUNT  = 30'h2000_0000;
    localparam logic [29:0] A_CMP    = 30'h2000_0001;
    localparam logic [29:0] A_TSTAT  = 30'h2000_0002;
    localparam logic [29:0] A_TXDATA = 30'h2000_0004;
    localparam logic [29:0] A_USTAT  = 30'h2000_0005;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Address decode on word address; byte offset is ignored.
    logic [29:0]        waddr;
    logic               sel_ram;
    logic [RAM_AW-1:0]  ram_idx;
    logic               unused_addr;

    assign waddr       = addr[31:2];
    assign sel_ram     = (addr[31:12] == 20'h0);
    assign ram_idx     = addr[2 +: RAM_AW];
    assign unused_addr = ^addr[1:0];

    logic wr_ram, wr_count, wr_cmp, wr_tstat, wr_txdata, wr_ustat;

    assign wr_ram    = wmem && sel_ram;
    assign wr_count  = wmem && !sel_ram && (waddr == A_COUNT);
    assign wr_cmp    = wmem && !sel_ram && (waddr == A_CMP);
    assign wr_tstat  = wmem && !sel_ram && (waddr == A_TSTAT);
    assign wr_txdata = wmem && !sel_ram && (waddr == A_TXDATA);
    assign wr_ustat  = wmem && !sel_ram && (waddr == A_USTAT);

    // Data RAM: contents survive reset.
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= wdata;
        end
    end

    // Timer: a match on the pre-edge count takes priority over a software clear.
    logic [31:0] count;
    logic [31:0] cmp;
    logic        flag;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            cmp   <= '1;
            flag  <= 1'b0;
        end else begin
            count <= wr_count ? wdata : count + 32'd1;
            if (wr_cmp) begin
                cmp <= wdata;
            end
            if (count == cmp) begin
                flag <= 1'b1;
            end else if (wr_tstat && wdata[0]) begin
                flag <= 1'b0;
            end
        end
    end

    assign timer_irq = flag;

    // TX FIFO; a push into a full FIFO is still taken if the UART pops that cycle.
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_CW-1:0] fifo_count;
    logic               overflow;
    logic               full;
    logic               empty;
    logic               push;
    logic               drop;
    logic               pop;

    assign full  = (fifo_count == FIFO_CW'(FIFO_DEPTH));
    assign empty = (fifo_count == '0);
    assign push  = wr_txdata && (!full || pop);
    assign drop  = wr_txdata && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FIFO_CW'(1);
                2'b01:   fifo_count <= fifo_count - FIFO_CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_ustat && wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // UART transmitter FSM
    state_t           state;
    state_t           state_next;
    logic [CPB_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_last;
    logic             busy;

    assign bit_last = (clk_cnt == CPB_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = START;
            START:   if (bit_last) state_next = DATA;
            DATA:    if (bit_last && (bit_idx == 3'd7)) state_next = STOP;
            STOP:    if (bit_last) state_next = empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop  = 1'b0;
        busy = 1'b1;
        txd  = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                pop  = !empty;
            end
            START:   txd = 1'b0;
            DATA:    txd = shift[0];
            STOP:    pop = bit_last && !empty;
            default: busy = 1'b0;
        endcase
    end

    // Bit timing and shift register
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            clk_cnt <= ((state == IDLE) || bit_last) ? '0 : clk_cnt + CPB_W'(1);
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_last) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                shift <= fifo_mem[rd_ptr];
            end else if ((state == DATA) && bit_last) begin
                shift <= {1'b0, shift[7:1]};
            end
        end
    end

    // Load data mux
    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = ram[ram_idx];
        end else begin
            case (waddr)
                A_COUNT:  rdata = count;
                A_CMP:    rdata = cmp;
                A_TSTAT:  rdata = {31'b0, flag};
                A_USTAT:  rdata = {24'b0, 4'(fifo_count), overflow, busy, full, empty};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_dbus.sv
// Bench for sc_dbus: constant vector table, hand-built timer/UART sequences and
// a randomized phase checked against a behavioural model and a serial decoder.
module tb_sc_dbus;

    localparam int unsigned CPB = 4;

    localparam logic [31:0] A_COUNT = 32'h8000_0000;
    localparam logic [31:0] A_CMP   = 32'h8000_0004;
    localparam logic [31:0] A_TSTAT = 32'h8000_0008;
    localparam logic [31:0] A_TX    = 32'h8000_0010;
    localparam logic [31:0] A_USTAT = 32'h8000_0014;

    logic        clk;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;
    logic        txd;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_flag;
    logic [31:0] ram_m [1024];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic        mon_en = 1'b0;

    sc_dbus #(
        .RAM_WORDS   (1024),
        .FIFO_DEPTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .addr     (addr),
        .wdata    (wdata),
        .wmem     (wmem),
        .rdata    (rdata),
        .txd      (txd),
        .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr  = a;
        wdata = d;
        wmem  = w;
        #1;
    endtask

    // Advance one clock, applying the timer/RAM rules to the model first.
    task automatic tick();
        logic wr;
        wr = wmem && !clr;
        if (wmem && (addr[31:12] == 20'h0)) ram_m[addr[11:2]] = wdata;
        if (clr) begin
            m_count = 32'h0;
            m_cmp   = 32'hFFFF_FFFF;
            m_flag  = 1'b0;
        end else begin
            if (m_count == m_cmp) m_flag = 1'b1;
            else if (wr && addr[31:2] == A_TSTAT[31:2] && wdata[0]) m_flag = 1'b0;
            if (wr && addr[31:2] == A_CMP[31:2]) m_cmp = wdata;
            m_count = (wr && addr[31:2] == A_COUNT[31:2]) ? wdata : m_count + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic drain();
        int n;
        n = 0;
        set(A_USTAT, 32'h0, 1'b0);
        while (rdata !== 32'h1 && n < 2000) begin
            tick();
            set(A_USTAT, 32'h0, 1'b0);
            n++;
        end
        chk("uart_drain", rdata, 32'h1);
    endtask

    // Serial decoder: samples each bit in its middle cycle.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                repeat (2) @(negedge clk);
                chk("mon_start", {31'b0, txd}, 32'h0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = txd;
                end
                repeat (CPB) @(negedge clk);
                chk("mon_stop", {31'b0, txd}, 32'h1);
                rx_q.push_back(b);
                @(negedge clk);
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        c;
        logic [31:0] e;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        int          r;
        int          n;

        vecs[0]  = '{32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0043, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[4]  = '{32'h0000_1040, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_0041, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{32'h0000_0FFE, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{32'h0000_0002, 32'h0,         1'b0, 1'b1, 32'h1111_1111};
        vecs[10] = '{A_TX,          32'h0,         1'b0, 1'b1, 32'h0};
        vecs[11] = '{32'h8000_000C, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[12] = '{A_CMP,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[13] = '{A_TSTAT,       32'h0,         1'b0, 1'b1, 32'h0};
        vecs[14] = '{32'h8000_0018, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[15] = '{A_USTAT,       32'h0,         1'b0, 1'b1, 32'h1};

        // Reset
        clr = 1'b1;
        set(A_USTAT, 32'h0, 1'b0);
        tick();
        tick();
        clr = 1'b0;
        set(A_USTAT, 32'h0, 1'b0);
        chk("rst_ustat", rdata, 32'h1);
        chk("rst_txd", {31'b0, txd}, 32'h1);
        chk("rst_irq", {31'b0, timer_irq}, 32'h0);
        set(A_CMP, 32'h0, 1'b0);
        chk("rst_cmp", rdata, 32'hFFFF_FFFF);
        set(A_COUNT, 32'h0, 1'b0);
        chk("rst_count", rdata, m_count);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            set(vecs[i].a, vecs[i].d, vecs[i].w);
            if (vecs[i].c) chk($sformatf("vec%0d", i), rdata, vecs[i].e);
            tick();
        end

        // Timer wrap, compare match and set-over-clear priority
        set(A_COUNT, 32'hFFFF_FFFE, 1'b1); tick();
        set(A_CMP, 32'h1, 1'b1); tick();
        set(A_COUNT, 32'h0, 1'b0);
        chk("tmr_ffff", rdata, 32'hFFFF_FFFF);
        tick();
        chk("tmr_wrap", rdata, 32'h0);
        tick();
        chk("tmr_one", rdata, 32'h1);
        chk("tmr_irq_pre", {31'b0, timer_irq}, 32'h0);
        tick();
        chk("tmr_irq_set", {31'b0, timer_irq}, 32'h1);
        set(A_TSTAT, 32'h0, 1'b0);
        chk("tmr_stat_set", rdata, 32'h1);
        set(A_TSTAT, 32'h1, 1'b1); tick();
        chk("tmr_irq_clr", {31'b0, timer_irq}, 32'h0);
        set(A_COUNT, 32'd9, 1'b1); tick();
        set(A_CMP, 32'd10, 1'b1); tick();
        set(A_TSTAT, 32'h1, 1'b1); tick();
        chk("tmr_set_wins", {31'b0, timer_irq}, 32'h1);
        set(A_TSTAT, 32'h1, 1'b1); tick();
        set(A_TSTAT, 32'h0, 1'b0);
        chk("tmr_clr2", rdata, 32'h0);

        // UART frame 0x55 then 0xA3 pushed during STOP, back to back
        set(A_TX, 32'h55, 1'b1); tick();
        set(A_USTAT, 32'h0, 1'b0);
        chk("tx_pre_txd", {31'b0, txd}, 32'h1);
        chk("tx_pre_stat", rdata, 32'h10);
        tick();
        for (int i = 0; i < 80; i++) begin
            if (i == 36) set(A_TX, 32'hA3, 1'b1);
            else set(A_USTAT, 32'h0, 1'b0);
            if (i == 10) chk("tx_busy_stat", rdata, 32'h05);
            b = (i < 40) ? 8'h55 : 8'hA3;
            chk($sformatf("tx_bit%0d", i), {31'b0, txd}, {31'b0, frame_bit(b, i % 40)});
            tick();
        end
        set(A_USTAT, 32'h0, 1'b0);
        chk("tx_idle_txd", {31'b0, txd}, 32'h1);
        chk("tx_idle_stat", rdata, 32'h1);

        // Overflow: ten consecutive pushes while idle
        for (int k = 0; k < 10; k++) begin
            set(A_TX, 32'h30 + 32'(k), 1'b1);
            tick();
        end
        set(A_USTAT, 32'h0, 1'b0);
        chk("ovf_stat", rdata, 32'h8E);
        set(A_USTAT, 32'h8, 1'b1); tick();
        set(A_USTAT, 32'h0, 1'b0);
        chk("ovf_clr", rdata, 32'h86);

        // Reset during DATA
        clr = 1'b1;
        set(A_USTAT, 32'h0, 1'b0);
        tick();
        clr = 1'b0;
        set(A_USTAT, 32'h0, 1'b0);
        chk("clr_txd", {31'b0, txd}, 32'h1);
        chk("clr_stat", rdata, 32'h1);
        set(32'h40, 32'h0, 1'b0);
        chk("clr_ram_kept", rdata, 32'hDEAD_BEEF);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (txd !== 1'b1) n++;
            tick();
        end
        chk("clr_no_frame", 32'(n), 32'h0);

        // Randomized phase against the model
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set(32'(i) << 2, $urandom, 1'b1);
            tick();
        end
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    set((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)), $urandom, 1'b1);
                    tick();
                end
                3, 4: begin
                    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                    set(a, 32'h0, 1'b0);
                    chk("rnd_ram", rdata, ram_m[a[11:2]]);
                    tick();
                end
                5: begin
                    a = $urandom | 32'h0010_0000;
                    set(a, $urandom, 1'($urandom_range(0, 1)));
                    chk("rnd_unmapped", rdata, 32'h0);
                    tick();
                end
                6: begin
                    set(A_COUNT, 32'h0, 1'b0);
                    chk("rnd_count", rdata, m_count);
                    tick();
                end
                7: begin
                    if ($urandom_range(0, 1) == 0) set(A_COUNT, $urandom, 1'b1);
                    else set(A_CMP, m_count + 32'($urandom_range(2, 6)), 1'b1);
                    tick();
                end
                8: begin
                    set(A_TSTAT, 32'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    chk("rnd_tstat", rdata, {31'b0, m_flag});
                    chk("rnd_irq", {31'b0, timer_irq}, {31'b0, m_flag});
                    tick();
                end
                default: begin
                    n = $urandom_range(1, 8);
                    for (int j = 0; j < n; j++) begin
                        b = 8'($urandom);
                        tx_q.push_back(b);
                        set(A_TX, {24'h0, b}, 1'b1);
                        tick();
                    end
                    drain();
                end
            endcase
        end
        drain();
        mon_en = 1'b0;
        chk("rx_count", 32'(rx_q.size()), 32'(tx_q.size()));
        for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), {24'h0, rx_q[i]}, {24'h0, tx_q[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
